// File: rtl/axi4_sram_pkg.sv
// Shared types and constants for the AXI4-to-SRAM endpoint.
//   state_e     : controller FSM states
//   Resp*       : AXI response codes
//   Burst*      : AXI burst type codes
//   resp_merge  : returns the more severe of two responses (DECERR > SLVERR > OKAY)
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

package axi4_sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdReq,
    StRdData
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == RespDecErr || b == RespDecErr) return RespDecErr;
    if (a == RespSlvErr || b == RespSlvErr) return RespSlvErr;
    return RespOkay;
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle (AW, W, B, AR, R channels) with master and slave modports.
//   aclk, aresetn : bus clock and synchronous active-low reset
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

interface axi4_if (
  input logic aclk,
  input logic aresetn
);
  logic [`AXI4_ID_WIDTH-1:0]     awid;
  logic [`AXI4_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic [`AXI4_USER_WIDTH-1:0]   awuser;
  logic                          awvalid;
  logic                          awready;
  logic [`AXI4_DATA_WIDTH-1:0]   wdata;
  logic [`AXI4_DATA_WIDTH/8-1:0] wstrb;
  logic                          wlast;
  logic [`AXI4_USER_WIDTH-1:0]   wuser;
  logic                          wvalid;
  logic                          wready;
  logic [`AXI4_ID_WIDTH-1:0]     bid;
  logic [1:0]                    bresp;
  logic [`AXI4_USER_WIDTH-1:0]   buser;
  logic                          bvalid;
  logic                          bready;
  logic [`AXI4_ID_WIDTH-1:0]     arid;
  logic [`AXI4_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic [`AXI4_USER_WIDTH-1:0]   aruser;
  logic                          arvalid;
  logic                          arready;
  logic [`AXI4_ID_WIDTH-1:0]     rid;
  logic [`AXI4_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic [`AXI4_USER_WIDTH-1:0]   ruser;
  logic                          rvalid;
  logic                          rready;

  modport slave (
    input  aclk, aresetn,
    input  awid, awaddr, awlen, awsize, awburst, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport master (
    input  aclk, aresetn,
    output awid, awaddr, awlen, awsize, awburst, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational burst address stepper.
//   addr_i      : current byte address
//   size_i      : log2 of bytes per beat
//   burst_i     : burst type (INCR advances, everything else holds)
//   next_addr_o : byte address of the following beat
//   oor_o       : current address maps beyond the last SRAM word
module axi4_burst_addr_gen
  import axi4_sram_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned MemDepth     = 1024,
  parameter int unsigned BytesPerWord = 4
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic [AddrWidth-1:0] next_addr_o,
  output logic                 oor_o
);
  localparam int unsigned ByteOffW = $clog2(BytesPerWord);
  localparam int unsigned MemAw    = $clog2(MemDepth);

  always_comb begin
    next_addr_o = addr_i;
    if (burst_i == BurstIncr) begin
      next_addr_o = addr_i + (AddrWidth'(1) << size_i);
    end
  end

  // Any set bit above the word-address field means word address >= MemDepth.
  assign oor_o = |addr_i[AddrWidth-1:ByteOffW+MemAw];

endmodule

// File: rtl/axi4_sram_ctrl.sv
// AXI4 slave terminating one transaction at a time onto a 1-cycle-latency SRAM.
//   aclk, aresetn : clock, synchronous active-low reset (same nets as the bus)
//   axi           : AXI4 slave port
//   sram_en/we    : access strobe / write enable
//   sram_addr     : word address
//   sram_wdata/wstrb : write data and byte mask straight from the W channel
//   sram_rdata    : read data, valid the cycle after a read strobe
module axi4_sram_ctrl
  import axi4_sram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  axi4_if.slave                           axi,
  output logic                            sram_en,
  output logic                            sram_we,
  output logic [MEM_AW-1:0]               sram_addr,
  output logic [`AXI4_DATA_WIDTH-1:0]     sram_wdata,
  output logic [`AXI4_DATA_WIDTH/8-1:0]   sram_wstrb,
  input  logic [`AXI4_DATA_WIDTH-1:0]     sram_rdata
);
  localparam int unsigned IdW      = `AXI4_ID_WIDTH;
  localparam int unsigned AddrW    = `AXI4_ADDR_WIDTH;
  localparam int unsigned DataW    = `AXI4_DATA_WIDTH;
  localparam int unsigned ByteOffW = $clog2(DataW / 8);

  state_e             state_q;
  logic               prio_wr_q;
  logic [IdW-1:0]     id_q;
  logic [AddrW-1:0]   addr_q;
  logic [7:0]         len_q;
  logic [2:0]         size_q;
  logic [1:0]         burst_q;
  logic [7:0]         cnt_q;
  logic [1:0]         wresp_q;
  logic               bvalid_q;
  logic [IdW-1:0]     bid_q;
  logic [1:0]         bresp_q;
  logic               rvalid_q;
  logic               rlast_q;
  logic [IdW-1:0]     rid_q;
  logic [1:0]         rresp_q;
  logic [DataW-1:0]   rdata_q;
  logic               rfresh_q;

  logic [AddrW-1:0]   next_addr;
  logic               beat_oor;
  logic               sel_wr, awready, arready, wready;
  logic               aw_hs, ar_hs, w_hs;
  logic               burst_err, beat_ok, last_beat;
  logic [1:0]         beat_resp, wresp_nxt;
  logic [DataW-1:0]   rdata_w;

  axi4_burst_addr_gen #(
    .AddrWidth    (AddrW),
    .MemDepth     (MEM_DEPTH),
    .BytesPerWord (DataW / 8)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr),
    .oor_o       (beat_oor)
  );

  // Lone requester wins; on contention serve the direction not served last.
  always_comb begin
    sel_wr = prio_wr_q;
    if (axi.awvalid && !axi.arvalid) sel_wr = 1'b1;
    else if (axi.arvalid && !axi.awvalid) sel_wr = 1'b0;
  end

  assign awready   = (state_q == StIdle) && aresetn && sel_wr;
  assign arready   = (state_q == StIdle) && aresetn && !sel_wr;
  assign wready    = (state_q == StWrData);
  assign aw_hs     = axi.awvalid && awready;
  assign ar_hs     = axi.arvalid && arready;
  assign w_hs      = axi.wvalid && wready;

  // WRAP (2'b10) and reserved (2'b11) both have bit 1 set.
  assign burst_err = burst_q[1];
  assign beat_ok   = !burst_err && !beat_oor;
  assign beat_resp = burst_err ? RespSlvErr : (beat_oor ? RespDecErr : RespOkay);
  assign last_beat = (cnt_q == len_q);
  assign wresp_nxt = resp_merge(wresp_q, resp_merge(beat_resp,
                       (axi.wlast != last_beat) ? RespSlvErr : RespOkay));

  assign sram_en    = (w_hs || state_q == StRdReq) && beat_ok;
  assign sram_we    = w_hs && beat_ok;
  assign sram_addr  = addr_q[ByteOffW +: MEM_AW];
  assign sram_wdata = axi.wdata;
  assign sram_wstrb = axi.wstrb;

  // First RD_DATA cycle forwards the macro output; later cycles replay the copy.
  assign rdata_w = rfresh_q ? sram_rdata : rdata_q;

  assign axi.awready = awready;
  assign axi.arready = arready;
  assign axi.wready  = wready;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.buser   = '0;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_w;
  assign axi.ruser   = '0;

  logic unused_sig;
  assign unused_sig = ^{axi.awuser, axi.wuser, axi.aruser, axi.aclk, axi.aresetn};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      wresp_q   <= RespOkay;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      rfresh_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (aw_hs) begin
            id_q      <= axi.awid;
            addr_q    <= axi.awaddr;
            len_q     <= axi.awlen;
            size_q    <= axi.awsize;
            burst_q   <= axi.awburst;
            cnt_q     <= '0;
            wresp_q   <= RespOkay;
            prio_wr_q <= 1'b0;
            state_q   <= StWrData;
          end else if (ar_hs) begin
            id_q      <= axi.arid;
            addr_q    <= axi.araddr;
            len_q     <= axi.arlen;
            size_q    <= axi.arsize;
            burst_q   <= axi.arburst;
            cnt_q     <= '0;
            prio_wr_q <= 1'b1;
            state_q   <= StRdReq;
          end
        end
        StWrData: begin
          if (w_hs) begin
            wresp_q <= wresp_nxt;
            addr_q  <= next_addr;
            if (last_beat) begin
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= wresp_nxt;
              state_q  <= StWrResp;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StWrResp: begin
          if (axi.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRdReq: begin
          rvalid_q <= 1'b1;
          rid_q    <= id_q;
          rresp_q  <= beat_resp;
          rlast_q  <= last_beat;
          rfresh_q <= beat_ok;
          rdata_q  <= '0;
          state_q  <= StRdData;
        end
        StRdData: begin
          rfresh_q <= 1'b0;
          rdata_q  <= rdata_w;
          if (axi.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            addr_q   <= next_addr;
            if (rlast_q) begin
              state_q <= StIdle;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              state_q <= StRdReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_ctrl.sv
// Self-checking bench for axi4_sram_ctrl: drives the bus as a master, models the
// SRAM macro, and checks responses against a scoreboard of expected B and R beats.
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module tb_axi4_sram_ctrl;
  import axi4_sram_pkg::*;

  localparam int unsigned Depth = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_rdata = '0;

  axi4_if bus (.aclk(clk), .aresetn(rstn));

  axi4_sram_ctrl #(.MEM_DEPTH(Depth)) dut (
    .aclk       (clk),
    .aresetn    (rstn),
    .axi        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wstrb (sram_wstrb),
    .sram_rdata (sram_rdata)
  );

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} exp_b_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} exp_r_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [Depth];
  logic [31:0] ref_mem [Depth];
  exp_b_t      exp_b[$];
  exp_r_t      exp_r[$];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  int          wlast_at;
  logic [9:0]  stb_addr[$];
  logic        stb_we[$];
  int          n_strobe = 0;
  byte         hs_log[$];
  int          b_wait;
  int          r_wait [256];

  // SRAM macro model: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (sram_en) begin
      n_strobe <= n_strobe + 1;
      stb_addr.push_back(sram_addr);
      stb_we.push_back(sram_we);
      if (sram_we) begin
        for (int i = 0; i < 4; i++) begin
          if (sram_wstrb[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      if (bus.awvalid && bus.awready) hs_log.push_back(8'h57);
      if (bus.arvalid && bus.arready) hs_log.push_back(8'h52);
    end
  end

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b11 || b == 2'b11) return 2'b11;
    if (a == 2'b10 || b == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic [1:0]  r;
    exp_b_t      e;
    a = addr;
    r = 2'b00;
    for (int b = 0; b <= int'(len); b++) begin
      if (burst[1]) begin
        r = worst(r, 2'b10);
      end else if (a[31:12] != 20'd0) begin
        r = worst(r, 2'b11);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (wstb[b][i]) ref_mem[a[11:2]][8*i +: 8] = wdat[b][8*i +: 8];
        end
      end
      if ((b == wlast_at) != (b == int'(len))) r = worst(r, 2'b10);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    e.id   = id;
    e.resp = r;
    exp_b.push_back(e);
  endtask

  task automatic model_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    exp_r_t      e;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      e.id   = id;
      e.last = (b == int'(len));
      if (burst[1]) begin
        e.resp = 2'b10;
        e.data = '0;
      end else if (a[31:12] != 20'd0) begin
        e.resp = 2'b11;
        e.data = '0;
      end else begin
        e.resp = 2'b00;
        e.data = ref_mem[a[11:2]];
      end
      exp_r.push_back(e);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cnt;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      if (bus.awready) break;
      cnt++;
      if (cnt > 50) begin
        n_cmp++; n_err++;
        $display("FAIL aw_timeout got awready=0 want 1 within 50 cycles");
        bus.awvalid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_drive(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cnt;
    ar_drive(id, addr, len, size, burst);
    cnt = 0;
    while (1) begin
      @(negedge clk);
      if (bus.arready) break;
      cnt++;
      if (cnt > 50) begin
        n_cmp++; n_err++;
        $display("FAIL ar_timeout got arready=0 want 1 within 50 cycles");
        bus.arvalid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [7:0] len);
    int cnt;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1; bus.wdata = wdat[b]; bus.wstrb = wstb[b]; bus.wlast = (b == wlast_at);
      cnt = 0;
      while (1) begin
        @(negedge clk);
        if (bus.wready) break;
        cnt++;
        if (cnt > 50) begin
          n_cmp++; n_err++;
          $display("FAIL w_timeout beat %0d got wready=0 want 1", b);
          bus.wvalid = 1'b0; bus.wlast = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_recv();
    exp_b_t e;
    int     cnt;
    bus.bready = 1'b1;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (bus.bvalid) break;
      if (cnt > 50) begin
        n_cmp++; n_err++;
        $display("FAIL b_timeout got bvalid=0 want 1");
        bus.bready = 1'b0;
        return;
      end
    end
    b_wait = cnt;
    n_cmp++;
    if (exp_b.size() == 0) begin
      n_err++;
      $display("FAIL b_unexpected got bresp=%0b want no response", bus.bresp);
    end else begin
      e = exp_b.pop_front();
      if ({bus.bid, bus.bresp} !== {e.id, e.resp}) begin
        n_err++;
        $display("FAIL b_resp got bid=%0h bresp=%0b want bid=%0h bresp=%0b",
                 bus.bid, bus.bresp, e.id, e.resp);
      end
    end
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic r_recv(input int n, input int stall);
    exp_r_t e;
    int     cnt;
    for (int b = 0; b < n; b++) begin
      bus.rready = (stall > 0 && b == 0) ? 1'b0 : 1'b1;
      cnt = 0;
      while (1) begin
        @(negedge clk);
        cnt++;
        if (bus.rvalid) break;
        if (cnt > 50) begin
          n_cmp++; n_err++;
          $display("FAIL r_timeout beat %0d got rvalid=0 want 1", b);
          bus.rready = 1'b0;
          return;
        end
      end
      r_wait[b] = cnt;
      e = exp_r.pop_front();
      n_cmp++;
      if (bus.rdata !== e.data) begin
        n_err++;
        $display("FAIL r_data beat %0d got %h want %h", b, bus.rdata, e.data);
      end
      n_cmp++;
      if ({bus.rid, bus.rresp, bus.rlast} !== {e.id, e.resp, e.last}) begin
        n_err++;
        $display("FAIL r_fields beat %0d got rid=%0h rresp=%0b rlast=%0b want %0h %0b %0b",
                 b, bus.rid, bus.rresp, bus.rlast, e.id, e.resp, e.last);
      end
      if (stall > 0 && b == 0) begin
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          n_cmp++;
          if ({bus.rvalid, bus.rdata} !== {1'b1, e.data}) begin
            n_err++;
            $display("FAIL r_stall cycle %0d got rvalid=%0b rdata=%h want 1 %h",
                     k, bus.rvalid, bus.rdata, e.data);
          end
        end
        bus.rready = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    model_write(id, addr, len, size, burst);
    aw_send(id, addr, len, size, burst);
    w_send(len);
    b_recv();
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall);
    model_read(id, addr, len, size, burst);
    ar_send(id, addr, len, size, burst);
    r_recv(int'(len) + 1, stall);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [63:0] obs;
    obs = {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, sram_en,
           sram_we, bus.bresp, bus.rresp, bus.bid, bus.rid, bus.rdata, 14'(sram_addr)};
    n_cmp++;
    if (obs !== 64'd0) begin
      n_err++;
      $display("FAIL %s got outputs=%h want 0", name, obs);
    end
  endtask

  task automatic test_reset();
    bus.awvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_simultaneous();
    byte want [4];
    int  base;
    want[0] = 8'h57; want[1] = 8'h52; want[2] = 8'h57; want[3] = 8'h52;
    base = hs_log.size();
    for (int round = 0; round < 2; round++) begin
      wdat[0] = 32'h1111_1111 * (round + 1); wstb[0] = 4'hF; wlast_at = 0;
      model_write(4'd1, 32'h100 + 32'(4 * round), 8'd0, 3'd2, 2'b01);
      model_read(4'd2, 32'h100 + 32'(4 * round), 8'd0, 3'd2, 2'b01);
      ar_drive(4'd2, 32'h100 + 32'(4 * round), 8'd0, 3'd2, 2'b01);
      aw_send(4'd1, 32'h100 + 32'(4 * round), 8'd0, 3'd2, 2'b01);
      w_send(8'd0);
      b_recv();
      ar_send(4'd2, 32'h100 + 32'(4 * round), 8'd0, 3'd2, 2'b01);
      r_recv(1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hs_log.size() <= base + i || hs_log[base + i] !== want[i]) begin
        n_err++;
        $display("FAIL arb_order[%0d] got %c want %c", i,
                 (hs_log.size() > base + i) ? hs_log[base + i] : 8'h2D, want[i]);
      end
    end
  endtask

  task automatic test_single();
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF; wlast_at = 0;
    do_write(4'd3, 32'h10, 8'd0, 3'd2, 2'b01);
    n_cmp++;
    if (b_wait !== 1) begin
      n_err++;
      $display("FAIL b_latency got %0d want 1", b_wait);
    end
    do_read(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 0);
    n_cmp++;
    if (r_wait[0] !== 2) begin
      n_err++;
      $display("FAIL r_latency got %0d want 2", r_wait[0]);
    end
  endtask

  task automatic test_incr();
    int base;
    for (int b = 0; b < 4; b++) begin
      wdat[b] = 32'hA000_0000 + 32'(b); wstb[b] = 4'hF;
    end
    wlast_at = 3;
    base = stb_addr.size();
    do_write(4'd6, 32'h0, 8'd3, 3'd2, 2'b01);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (stb_addr.size() <= base + b || {stb_we[base + b], stb_addr[base + b]} !== {1'b1, 10'(b)}) begin
        n_err++;
        $display("FAIL incr_wr_addr beat %0d got %0d want %0d", b,
                 (stb_addr.size() > base + b) ? stb_addr[base + b] : 10'h3FF, b);
      end
    end
    base = stb_addr.size();
    do_read(4'd7, 32'h0, 8'd3, 3'd2, 2'b01, 0);
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (stb_addr.size() <= base + b || {stb_we[base + b], stb_addr[base + b]} !== {1'b0, 10'(b)}
          || r_wait[b] !== 2) begin
        n_err++;
        $display("FAIL incr_rd_beat %0d got wait=%0d want addr %0d wait 2", b, r_wait[b], b);
      end
    end
  endtask

  task automatic test_narrow();
    for (int b = 0; b < 4; b++) begin
      wdat[b] = {4{8'h10 + 8'(b)}}; wstb[b] = 4'b0001 << b;
    end
    wlast_at = 3;
    do_write(4'd8, 32'h20, 8'd3, 3'd0, 2'b01);
    do_read(4'd8, 32'h20, 8'd0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_oor();
    wdat[0] = 32'hCAFE_F00D; wdat[1] = 32'h1234_5678; wstb[0] = 4'hF; wstb[1] = 4'hF;
    wlast_at = 1;
    do_write(4'd9, 32'hFFC, 8'd1, 3'd2, 2'b01);
    do_read(4'd9, 32'hFFC, 8'd1, 3'd2, 2'b01, 0);
  endtask

  task automatic test_wrap_wlast();
    int s0;
    wdat[0] = 32'h0BAD_0BAD; wdat[1] = 32'h0BAD_0BAD; wstb[0] = 4'hF; wstb[1] = 4'hF;
    wlast_at = 1;
    s0 = n_strobe;
    do_write(4'd10, 32'h40, 8'd1, 3'd2, 2'b10);
    do_read(4'd10, 32'h40, 8'd1, 3'd2, 2'b10, 0);
    n_cmp++;
    if (n_strobe !== s0) begin
      n_err++;
      $display("FAIL wrap_strobes got %0d want 0", n_strobe - s0);
    end
    for (int b = 0; b < 4; b++) begin
      wdat[b] = 32'h7700_0000 + 32'(b); wstb[b] = 4'hF;
    end
    wlast_at = 1;
    do_write(4'd11, 32'h80, 8'd3, 3'd2, 2'b01);
  endtask

  task automatic test_backpressure();
    wdat[0] = 32'h5A5A_1234; wstb[0] = 4'hF; wlast_at = 0;
    do_write(4'd12, 32'h200, 8'd0, 3'd2, 2'b00);
    do_read(4'd13, 32'h200, 8'd0, 3'd2, 2'b00, 5);
  endtask

  task automatic test_reset_midburst();
    logic seen_b;
    aw_send(4'd1, 32'h300, 8'd3, 3'd2, 2'b01);
    bus.wvalid = 1'b1; bus.wdata = 32'h3333_0000; bus.wstrb = 4'hF; bus.wlast = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("reset_midburst");
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    seen_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.bvalid || bus.rvalid) seen_b = 1'b1;
    end
    n_cmp++;
    if (seen_b !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_resp got response=1 want 0");
    end
    bus.bready = 1'b0;
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awuser = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wuser = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.aruser = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < int'(Depth); i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    test_reset();
    test_simultaneous();
    test_single();
    test_incr();
    test_narrow();
    test_oor();
    test_wrap_wlast();
    test_backpressure();
    test_reset_midburst();
    n_cmp++;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expect got b=%0d r=%0d want 0 0", exp_b.size(), exp_r.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
